cpu040_wb_bridge: RTL

- Second-generation 68040-to-Wishbone bridge, clocked directly on the CPU bus clock, so it needs no phase detector.
- Translates 68040 byte, word, long and line transfers into Wishbone B4 cycles. Line transfers carry registered-feedback burst tags.
- Adds transfer-error termination (TEA) on Wishbone error, ack timeout and unsupported transfer types.
- Contains the parametrised CPU reset/cache-disable sequencer and sits between the CPU pad ring and the system Wishbone interconnect.

---
 rtl/cpu040_wb_bridge.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/cpu040_wb_bridge.sv
// 68040 bus to Wishbone B4 bridge, clocked on the CPU bus clock.
// Includes the CPU reset / cache-disable sequencer.
module cpu040_wb_bridge #(
  parameter int TIMEOUT     = 255,
  parameter int RST_CPU_CYC = 256,
  parameter int RST_FSM_CYC = 776,
  parameter bit BURST_TAGS  = 1'b1
) (
  input  logic        bclk,
  input  logic        reset,
  input  logic [31:0] cpu_ad_o,
  output logic [31:0] cpu_ad_i,
  output logic        cpu_ad_t,
  input  logic [1:0]  cpu_siz,
  input  logic [1:0]  cpu_tt,
  input  logic        cpu_ts,
  input  logic        cpu_rw,
  output logic        cpu_ta,
  output logic        cpu_tea,
  output logic        cpu_rsti,
  output logic        cpu_cdis,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [29:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  output logic        busy_o
);

  localparam int CW = $clog2(RST_FSM_CYC + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(RST_FSM_CYC + 1);
  localparam logic [CW-1:0] CPU_LIM = CW'(RST_CPU_CYC);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRIVE,
    ERR
  } state_t;

  state_t        state;
  logic [CW-1:0] rst_cnt;
  logic [TW-1:0] tcnt;
  logic [1:0]    beats;
  logic          rw_q;
  logic          line_q;
  logic          ready;
  logic          line_d;
  logic [3:0]    sel_d;

  assign ready    = (rst_cnt == CNT_MAX);
  assign cpu_rsti = (rst_cnt > CPU_LIM);
  assign cpu_cdis = ready;
  assign busy_o   = (state != IDLE);

  function automatic logic [2:0] cti_for(input logic line, input logic last);
    if (BURST_TAGS && line) return last ? 3'b111 : 3'b010;
    return 3'b000;
  endfunction

  // MOVE16 is always a full line regardless of the size code
  always_comb begin
    line_d = (cpu_siz == 2'b11) || (cpu_tt == 2'b01);
    sel_d  = 4'b1111;
    if (!line_d) begin
      unique case (cpu_siz)
        2'b01:   sel_d = 4'b1000 >> cpu_ad_o[1:0];
        2'b10:   sel_d = cpu_ad_o[1] ? 4'b0011 : 4'b1100;
        default: sel_d = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge bclk) begin
    if (reset) begin
      state    <= IDLE;
      rst_cnt  <= '0;
      tcnt     <= '0;
      beats    <= '0;
      rw_q     <= 1'b1;
      line_q   <= 1'b0;
      cpu_ad_i <= '0;
      cpu_ad_t <= 1'b1;
      cpu_ta   <= 1'b1;
      cpu_tea  <= 1'b1;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_cti_o <= 3'b000;
      wb_bte_o <= 2'b00;
    end else begin
      if (!ready) rst_cnt <= rst_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (ready && !cpu_ts) begin
            wb_adr_o <= cpu_ad_o[31:2];
            wb_sel_o <= sel_d;
            rw_q     <= cpu_rw;
            line_q   <= line_d;
            beats    <= line_d ? 2'd3 : 2'd0;
            if (cpu_tt[1]) begin
              cpu_tea <= 1'b0;
              state   <= ERR;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o  <= !rw_q;
          if (!rw_q) wb_dat_o <= cpu_ad_o;
          wb_cti_o <= cti_for(line_q, beats == 2'd0);
          wb_bte_o <= (BURST_TAGS && line_q) ? 2'b01 : 2'b00;
          tcnt     <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wb_err_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            cpu_tea  <= 1'b0;
            state    <= ERR;
          end else if (wb_ack_i) begin
            wb_stb_o <= 1'b0;
            if (beats == 2'd0) wb_cyc_o <= 1'b0;
            cpu_ta <= 1'b0;
            if (rw_q) begin
              cpu_ad_i <= wb_dat_i;
              cpu_ad_t <= 1'b0;
            end
            state <= DRIVE;
          end else if (TIMEOUT != 0 && tcnt == TLIM) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            cpu_tea  <= 1'b0;
            state    <= ERR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DRIVE: begin
          cpu_ta   <= 1'b1;
          cpu_ad_t <= 1'b1;
          // next beat re-enters the request phase with stb back up
          if (beats != 2'd0) begin
            beats         <= beats - 2'd1;
            wb_adr_o[1:0] <= wb_adr_o[1:0] + 2'd1;
            wb_stb_o      <= 1'b1;
            if (!rw_q) wb_dat_o <= cpu_ad_o;
            wb_cti_o <= cti_for(line_q, beats == 2'd1);
            tcnt     <= '0;
            state    <= WAIT;
          end else begin
            wb_cti_o <= 3'b000;
            wb_bte_o <= 2'b00;
            wb_we_o  <= 1'b0;
            state    <= IDLE;
          end
        end
        ERR: begin
          cpu_tea  <= 1'b1;
          wb_cti_o <= 3'b000;
          wb_bte_o <= 2'b00;
          wb_we_o  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
